// File: rtl/ram8_write_if.sv
// Bus bundle for ram8_write: write data/enable/address in, read data and ready out.
interface ram8_write_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [2:0]       address;
  logic [WIDTH-1:0] out;
  logic             ready;

  modport master (output in, output load, output address, input out, input ready);
  modport slave  (input in, input load, input address, output out, output ready);
endinterface

// File: rtl/ram8_write.sv
// Eight-word RAM with a self-clearing start-up phase and combinational read.
// Optional macro RAM8_WRITE_BYPASS_EN forwards pending write data to out in RUN.
module ram8_write #(
  parameter int unsigned WIDTH = 16
) (
  input logic          clk,
  input logic          reset,
  ram8_write_if.slave  bus
);

  typedef enum logic {StClear, StRun} state_e;

  state_e           state;
  logic [2:0]       cnt;
  logic             ready_q;
  logic [WIDTH-1:0] mem [8];

  logic [2:0]       waddr;
  logic [WIDTH-1:0] wdata;
  logic [7:0]       we;

  // CLEAR owns the write port; bus inputs only reach storage in RUN.
  always_comb begin
    we    = '0;
    waddr = (state == StClear) ? cnt : bus.address;
    wdata = (state == StClear) ? '0 : bus.in;
    if (!reset && (state == StClear || bus.load)) begin
      we[waddr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StClear;
      cnt     <= 3'd0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        StClear: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state   <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          state   <= StRun;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= StClear;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) begin
        mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    bus.out = '0;
    if (state == StRun) begin
`ifdef RAM8_WRITE_BYPASS_EN
      bus.out = bus.load ? bus.in : mem[bus.address];
`else
      bus.out = mem[bus.address];
`endif
    end
  end

  assign bus.ready = ready_q;

endmodule

// File: tb/tb_ram8_write.sv
// Self-checking bench for ram8_write: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_ram8_write;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic reset;

  ram8_write_if #(.WIDTH(W)) bus ();

  ram8_write #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: word array plus number of clear edges still to come.
  logic [W-1:0] m [8];
  int           clear_left = 8;
  int           compared   = 0;
  int           mismatched = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_out();
    if (clear_left != 0) return '0;
`ifdef RAM8_WRITE_BYPASS_EN
    if (bus.load) return bus.in;
`endif
    return m[bus.address];
  endfunction

  // One clock edge: update the model from the inputs seen at the edge, then check ready.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      clear_left = 8;
    end else if (clear_left > 0) begin
      m[8 - clear_left] = '0;
      clear_left--;
    end else if (bus.load) begin
      m[bus.address] = bus.in;
    end
    @(negedge clk);
    check("ready", {15'b0, bus.ready}, {15'b0, (clear_left == 0)});
  endtask

  task automatic drive(input logic ld, input logic [2:0] a, input logic [W-1:0] d);
    bus.load    = ld;
    bus.address = a;
    bus.in      = d;
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, a[2:0], W'($urandom));
      check(tag, bus.out, exp_out());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [W-1:0] pat [8];

  initial begin
    pat[0] = 16'h5500; pat[1] = 16'h55FF; pat[2] = 16'hAA00; pat[3] = 16'hAAFF;
    pat[4] = 16'h0055; pat[5] = 16'hFF55; pat[6] = 16'h00AA; pat[7] = 16'hFFAA;
    reset = 1'b1;
    drive(1'b0, 3'd0, '0);

    // Power-up clear: out stays 0, ready rises on the 8th edge after reset.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, W'($urandom) & 3'h7, W'($urandom));
      check("clear_out", bus.out, 16'h0000);
      tick();
    end
    check("ready_after_clear", {15'b0, bus.ready}, 16'h0001);
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, a[2:0], '0);
      check("zero_after_clear", bus.out, 16'h0000);
    end

    // Distinct pattern per word, then read-back sweep.
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, a[2:0], pat[a]);
      tick();
    end
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, a[2:0], '0);
      check("pattern_sweep", bus.out, pat[a]);
    end

    // Write-before-edge visibility.
    drive(1'b1, 3'd3, 16'h1234);
    tick();
    drive(1'b1, 3'd3, 16'hBEEF);
`ifdef RAM8_WRITE_BYPASS_EN
    check("pre_edge_bypass", bus.out, 16'hBEEF);
`else
    check("pre_edge_old", bus.out, 16'h1234);
`endif
    tick();
    drive(1'b0, 3'd3, '0);
    check("post_edge", bus.out, 16'hBEEF);

    // Writes attempted during clear are ignored.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k == 1) drive(1'b1, 3'd2, 16'hFFFF);
      else drive(1'($urandom), W'($urandom) & 3'h7, W'($urandom));
      check("clear_out_load", bus.out, 16'h0000);
      tick();
    end
    drive(1'b0, 3'd2, '0);
    check("clear_ignores_load", bus.out, 16'h0000);
    sweep("sweep_after_clear2");

    // Reset with a concurrent write restarts the clear and wipes the word.
    drive(1'b1, 3'd5, 16'hCAFE);
    tick();
    drive(1'b0, 3'd5, '0);
    check("cafe_written", bus.out, 16'hCAFE);
    drive(1'b1, 3'd5, 16'h1111);
    do_reset();
    check("ready_drop", {15'b0, bus.ready}, 16'h0000);
    drive(1'b0, 3'd5, '0);
    for (int k = 0; k < 8; k++) tick();
    check("reset_wipes_cafe", bus.out, 16'h0000);

    // Back-to-back writes to address 7, last one wins.
    for (int a = 0; a < 7; a++) begin
      drive(1'b1, a[2:0], 16'h0100 + 16'(a));
      tick();
    end
    drive(1'b1, 3'd7, 16'h0001); tick();
    drive(1'b1, 3'd7, 16'h0002); tick();
    drive(1'b1, 3'd7, 16'h0003); tick();
    drive(1'b1, 3'd7, 16'h8001); tick();
    drive(1'b0, 3'd7, '0);
    check("addr7_last_wins", bus.out, 16'h8001);
    for (int a = 0; a < 7; a++) begin
      drive(1'b0, a[2:0], '0);
      check("addr7_no_alias", bus.out, 16'h0100 + 16'(a));
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive(1'($urandom), W'($urandom) & 3'h7, W'($urandom));
      check("rand_out", bus.out, exp_out());
      tick();
    end
    reset = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    sweep("final_sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
